// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the IF/ID stage: opcodes, instruction field
// positions and the entry type held by the pipeline register.
package mips_pkg;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  // Widest PC the held entry can carry; narrower PCs are zero-extended into it.
  localparam int PC_MAX_W = 32;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_MAX_W-1:0] pc;
  } ifid_entry_t;

  // Logical immediates and LUI take a zero-extended immediate.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Handshake and decode-field bundle between fetch, the IF/ID stage and decode.
interface if_id_stage_if #(
  parameter int PC_W = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_pc_plus4;
  logic [5:0]      out_op;
  logic [5:0]      out_funct;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [15:0]     out_imm;
  logic            out_imm_zext;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_plus4,
           out_op, out_funct, out_rs, out_rt, out_rd, out_shamt,
           out_imm, out_imm_zext
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_plus4,
           out_op, out_funct, out_rs, out_rt, out_rd, out_shamt,
           out_imm, out_imm_zext
  );

endinterface

// File: rtl/ifid_field_decode.sv
// Purely combinational split of a MIPS instruction word into its fields,
// plus the zero/sign extension mode for the immediate extender.
module ifid_field_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        imm_zext
);

  assign op       = instr[OP_HI:OP_LO];
  assign rs       = instr[RS_HI:RS_LO];
  assign rt       = instr[RT_HI:RT_LO];
  assign rd       = instr[RD_HI:RD_LO];
  assign shamt    = instr[SHAMT_HI:SHAMT_LO];
  assign funct    = instr[FUNCT_HI:FUNCT_LO];
  assign imm      = instr[IMM_HI:IMM_LO];
  assign imm_zext = is_zext_op(op);

endmodule

// File: rtl/if_id_stage.sv
// Registered IF/ID pipeline stage. Define IFID_SKID_EN for a two-entry
// (main + skid) build whose in_ready is registered; default is single-entry.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int PC_W = 32
) (
  input logic            clk,
  input logic            rst,
  if_id_stage_if.slave   bus
);

  logic        main_valid;
  ifid_entry_t main_q;
  ifid_entry_t in_entry;
  logic        in_fire;
  logic        out_fire;

  assign in_entry.instr = bus.in_instr;
  assign in_entry.pc    = PC_MAX_W'(bus.in_pc);
  assign in_fire        = bus.in_valid && bus.in_ready;
  assign out_fire       = main_valid && bus.out_ready;

`ifdef IFID_SKID_EN
  logic        skid_valid;
  ifid_entry_t skid_q;

  assign bus.in_ready = !skid_valid;

  // Main refills from skid first to keep acceptance order; skid only
  // catches a beat that arrives while main is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) main_q <= in_entry;
      end
    end else if (in_fire) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end
`else
  assign bus.in_ready = !main_valid || out_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_q     <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      main_valid <= in_fire;
      if (in_fire) main_q <= in_entry;
    end
  end
`endif

  assign bus.out_valid    = main_valid;
  assign bus.out_instr    = main_q.instr;
  assign bus.out_pc       = main_q.pc[PC_W-1:0];
  assign bus.out_pc_plus4 = bus.out_pc + PC_W'(4);

  ifid_field_decode u_decode (
    .instr    (main_q.instr),
    .op       (bus.out_op),
    .funct    (bus.out_funct),
    .rs       (bus.out_rs),
    .rt       (bus.out_rt),
    .rd       (bus.out_rd),
    .shamt    (bus.out_shamt),
    .imm      (bus.out_imm),
    .imm_zext (bus.out_imm_zext)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage against a FIFO reference model whose
// capacity follows the IFID_SKID_EN build option.
module tb_if_id_stage;

`ifdef IFID_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  ent_t q[$];

  if_id_stage_if #(.PC_W(32)) bus ();

  if_id_stage #(.PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit exp_in_ready();
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || (bus.out_ready == 1'b1);
  endfunction

  function automatic bit exp_zext(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    return (op >= 6'h0C) && (op <= 6'h0F);
  endfunction

  task automatic drive(input bit v, input logic [31:0] i, input logic [31:0] p,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_instr  = i;
    bus.in_pc     = p;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic advance();
    bit   acc;
    bit   cons;
    ent_t e;
    acc     = bus.in_valid && exp_in_ready();
    cons    = (q.size() > 0) && bus.out_ready;
    e.instr = bus.in_instr;
    e.pc    = bus.in_pc;
    @(posedge clk);
    if (bus.flush) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 32'h0, 32'h0, 0, 0);
    rst = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_pc_plus4 !== 32'h4) begin failures++; $display("[TB] FAIL reset_pc_plus4: got %h want 00000004", bus.out_pc_plus4); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr: got %h want 0", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h want 0", bus.out_pc); end
    checks++; if ({bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct} !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_fields: got %h want 0", {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct}); end
    checks++; if (bus.out_imm !== 16'h0) begin failures++; $display("[TB] FAIL reset_imm: got %h want 0", bus.out_imm); end
    checks++; if (bus.out_imm_zext !== 1'b0) begin failures++; $display("[TB] FAIL reset_zext: got %0b want 0", bus.out_imm_zext); end
    advance();
  endtask

  task automatic test_lui_addi();
    drive(1, 32'h3C01_1234, 32'h0040_0000, 1, 0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL lui_in_ready: got %0b want 1", bus.in_ready); end
    advance();
    drive(1, 32'h2021_FFFF, 32'h0040_0004, 1, 0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL lui_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_op !== 6'h0F) begin failures++; $display("[TB] FAIL lui_op: got %h want 0f", bus.out_op); end
    checks++; if (bus.out_rt !== 5'd1) begin failures++; $display("[TB] FAIL lui_rt: got %0d want 1", bus.out_rt); end
    checks++; if (bus.out_imm !== 16'h1234) begin failures++; $display("[TB] FAIL lui_imm: got %h want 1234", bus.out_imm); end
    checks++; if (bus.out_imm_zext !== 1'b1) begin failures++; $display("[TB] FAIL lui_zext: got %0b want 1", bus.out_imm_zext); end
    checks++; if (bus.out_pc_plus4 !== 32'h0040_0004) begin failures++; $display("[TB] FAIL lui_pc_plus4: got %h want 00400004", bus.out_pc_plus4); end
    advance();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if (bus.out_instr !== 32'h2021_FFFF) begin failures++; $display("[TB] FAIL addi_instr: got %h want 2021ffff", bus.out_instr); end
    checks++; if (bus.out_imm_zext !== 1'b0) begin failures++; $display("[TB] FAIL addi_zext: got %0b want 0", bus.out_imm_zext); end
    checks++; if (bus.out_pc_plus4 !== 32'h0040_0008) begin failures++; $display("[TB] FAIL addi_pc_plus4: got %h want 00400008", bus.out_pc_plus4); end
    advance();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL addi_drained: got %0b want 0", bus.out_valid); end
    advance();
  endtask

  task automatic test_stall();
    ent_t items[3];
    int   idx;
    int   accepted;
    idx = 0;
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      items[i].instr = $urandom;
      items[i].pc    = 32'h0040_1000 + 32'(i * 4);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(idx < 3, (idx < 3) ? items[idx].instr : 32'h0, (idx < 3) ? items[idx].pc : 32'h0, 0, 0);
      @(negedge clk);
      checks++; if (bus.in_ready !== exp_in_ready()) begin failures++; $display("[TB] FAIL stall_in_ready c%0d: got %0b want %0b", cyc, bus.in_ready, exp_in_ready()); end
      if (cyc > 0) begin
        checks++; if (bus.out_instr !== items[0].instr || bus.out_valid !== 1'b1) begin
          failures++; $display("[TB] FAIL stall_hold c%0d: got %h/%0b want %h/1", cyc, bus.out_instr, bus.out_valid, items[0].instr); end
      end
      if (bus.in_valid && bus.in_ready) accepted++;
      if (bus.in_valid && exp_in_ready()) idx++;
      advance();
    end
    checks++; if (accepted != DEPTH) begin failures++; $display("[TB] FAIL stall_accept_count: got %0d want %0d", accepted, DEPTH); end
    drive(0, 32'h0, 32'h0, 1, 0);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== items[k].instr) begin
        failures++; $display("[TB] FAIL stall_drain%0d: got %h/%0b want %h/1", k, bus.out_instr, bus.out_valid, items[k].instr); end
      advance();
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_empty: got %0b want 0", bus.out_valid); end
    advance();
  endtask

  task automatic test_flush();
    logic [31:0] f[3];
    for (int i = 0; i < 3; i++) f[i] = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, f[i], 32'h0050_0000 + 32'(i * 4), 0, 0);
      @(negedge clk);
      advance();
    end
    drive(1, f[2], 32'h0050_0008, 1, 1);
    @(negedge clk);
    advance();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready: got %0b want 1", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      advance();
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_resurrect%0d: got valid %0b instr %h want 0", i, bus.out_valid, bus.out_instr); end
    end
    advance();
  endtask

  task automatic test_async_reset();
    drive(1, 32'h8C22_0010, 32'h0060_0000, 0, 0);
    @(negedge clk);
    advance();
    drive(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    checks++; if (bus.out_instr !== 32'h8C22_0010) begin failures++; $display("[TB] FAIL areset_pre: got %h want 8c220010", bus.out_instr); end
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("[TB] FAIL areset_instr: got %h want 0", bus.out_instr); end
    checks++; if (bus.out_pc_plus4 !== 32'h4) begin failures++; $display("[TB] FAIL areset_pc_plus4: got %h want 00000004", bus.out_pc_plus4); end
    #1;
    rst = 1'b0;
    advance();
    drive(0, 32'h0, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_resurrect%0d: got %0b want 0", i, bus.out_valid); end
      advance();
    end
  endtask

  task automatic test_wrap();
    drive(1, 32'h3402_00FF, 32'hFFFF_FFFC, 1, 0);
    @(negedge clk);
    advance();
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    checks++; if (bus.out_pc !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_pc: got %h want fffffffc", bus.out_pc); end
    checks++; if (bus.out_pc_plus4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pc_plus4: got %h want 00000000", bus.out_pc_plus4); end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    bit          v;
    bit          ordy;
    bit          fl;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v     = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 3) != 0);
      fl    = ($urandom_range(0, 19) == 0);
      instr = $urandom;
      if ($urandom_range(0, 1) == 1) instr[31:26] = 6'h0C + 6'($urandom_range(0, 3));
      pc = $urandom;
      pc[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      drive(v, instr, pc, ordy, fl);
      @(negedge clk);
      checks++; if (bus.out_valid !== (q.size() > 0)) begin failures++; $display("[TB] FAIL rand_valid c%0d: got %0b want %0b", cyc, bus.out_valid, q.size() > 0); end
      checks++; if (bus.in_ready !== exp_in_ready()) begin failures++; $display("[TB] FAIL rand_in_ready c%0d: got %0b want %0b", cyc, bus.in_ready, exp_in_ready()); end
      if (q.size() > 0) begin
        e_instr = q[0].instr;
        e_pc    = q[0].pc;
        checks++; if (bus.out_instr !== e_instr) begin failures++; $display("[TB] FAIL rand_instr c%0d: got %h want %h", cyc, bus.out_instr, e_instr); end
        checks++; if (bus.out_pc !== e_pc) begin failures++; $display("[TB] FAIL rand_pc c%0d: got %h want %h", cyc, bus.out_pc, e_pc); end
        checks++; if (bus.out_pc_plus4 !== e_pc + 32'd4) begin failures++; $display("[TB] FAIL rand_pc_plus4 c%0d: got %h want %h", cyc, bus.out_pc_plus4, e_pc + 32'd4); end
        checks++; if ({bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct} !== e_instr) begin
          failures++; $display("[TB] FAIL rand_fields c%0d: got %h want %h", cyc, {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct}, e_instr); end
        checks++; if (bus.out_imm !== e_instr[15:0]) begin failures++; $display("[TB] FAIL rand_imm c%0d: got %h want %h", cyc, bus.out_imm, e_instr[15:0]); end
        checks++; if (bus.out_imm_zext !== exp_zext(e_instr)) begin failures++; $display("[TB] FAIL rand_zext c%0d: got %0b want %0b", cyc, bus.out_imm_zext, exp_zext(e_instr)); end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);
    test_reset();
    test_lui_addi();
    test_stall();
    test_flush();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
